// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM generator.
// Holds the default geometry, the mode encoding and the counter direction type.
package pwm_pkg;

   localparam int DEF_WIDTH  = 10;
   localparam int DEF_NCH    = 4;
   localparam int PERIOD_MIN = 2;

   localparam logic MODE_EDGE   = 1'b0;
   localparam logic MODE_CENTER = 1'b1;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   // A single channel still needs a one-bit selector.
   function automatic int chanSelWidth(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// Command and drive-pin bundle between the register interface and pwm_multi.
// The master side issues run/mode/period and duty writes; the slave side returns the PWM pins.
interface pwm_multi_if import pwm_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NCH   = DEF_NCH
);

   localparam int CHW = chanSelWidth(NCH);

   logic             en;
   logic             mode;
   logic [WIDTH-1:0] period;
   logic             duty_wr;
   logic [CHW-1:0]   duty_ch;
   logic [WIDTH-1:0] duty_val;
   logic [NCH-1:0]   pwm_out;
   logic             period_start;

   modport master (
      output en, mode, period, duty_wr, duty_ch, duty_val,
      input  pwm_out, period_start
   );

   modport slave (
      input  en, mode, period, duty_wr, duty_ch, duty_val,
      output pwm_out, period_start
   );

endinterface

// File: rtl/pwm_chan.sv
// One PWM compare channel: shadow duty, active duty, compare and registered output.
// Compares against the duty/period/mode that are in force for the cycle being evaluated.
module pwm_chan import pwm_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic [WIDTH-1:0] cnt_i,
   input  logic [WIDTH-1:0] period_i,
   input  logic             mode_i,
   input  logic             load_i,
   input  logic             wr_i,
   input  logic [WIDTH-1:0] wr_val_i,
   output logic             pwm_o
);

   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [WIDTH-1:0] activeDuty_q, activeDuty_d;
   logic             pwm_q, pwm_d;
   logic             hit;

   // The load takes the old shadow, so a write on a boundary waits one more period.
   assign activeDuty_d = load_i ? shadow_q : activeDuty_q;
   assign shadow_d     = wr_i ? wr_val_i : shadow_q;

   // Explicit 0 and >=P cases keep the output flat across the wrap in both modes.
   always_comb begin
      hit = 1'b0;
      if (activeDuty_d == '0) begin
         hit = 1'b0;
      end else if (activeDuty_d >= period_i) begin
         hit = 1'b1;
      end else if (mode_i == MODE_CENTER) begin
         hit = (cnt_i >= (period_i - activeDuty_d));
      end else begin
         hit = (cnt_i < activeDuty_d);
      end
   end

   assign pwm_d = en_i && hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q     <= '0;
         activeDuty_q <= '0;
         pwm_q        <= 1'b0;
      end else begin
         shadow_q     <= shadow_d;
         activeDuty_q <= activeDuty_d;
         pwm_q        <= pwm_d;
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM top: shared up or up/down period counter, boundary detection,
// active period/mode registers, duty write decode and NCH compare channels.
module pwm_multi import pwm_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NCH   = DEF_NCH
) (
   input  logic       clk,
   input  logic       rst,
   pwm_multi_if.slave bus
);

   localparam int               CHW  = chanSelWidth(NCH);
   localparam logic [WIDTH-1:0] PMIN = WIDTH'(PERIOD_MIN);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   dir_e             dir_q, dir_d;
   logic [WIDTH-1:0] activePeriod_q, activePeriod_d;
   logic             activeMode_q, activeMode_d;
   logic             periodStart_q;
   logic             boundary, load;
   logic [WIDTH-1:0] periodClamped, lastCnt;
   logic [NCH-1:0]   wrStrobe, pwmOut;

   // While disabled the active set tracks the inputs so the first enabled period is current.
   assign boundary       = bus.en && (cnt_q == '0) && (dir_q == DIR_UP);
   assign load           = boundary || !bus.en;
   assign periodClamped  = (bus.period < PMIN) ? PMIN : bus.period;
   assign activePeriod_d = load ? periodClamped : activePeriod_q;
   assign activeMode_d   = load ? bus.mode : activeMode_q;
   assign lastCnt        = activePeriod_d - 1'b1;

   // Center mode repeats both end values so each count appears twice per period.
   always_comb begin
      cnt_d = cnt_q;
      dir_d = dir_q;
      if (!bus.en) begin
         cnt_d = '0;
         dir_d = DIR_UP;
      end else if (activeMode_d == MODE_EDGE) begin
         dir_d = DIR_UP;
         cnt_d = (cnt_q == lastCnt) ? '0 : cnt_q + 1'b1;
      end else if (dir_q == DIR_UP) begin
         if (cnt_q == lastCnt) begin
            dir_d = DIR_DOWN;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         if (cnt_q == '0) begin
            dir_d = DIR_UP;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q          <= '0;
         dir_q          <= DIR_UP;
         activePeriod_q <= PMIN;
         activeMode_q   <= MODE_EDGE;
         periodStart_q  <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         dir_q          <= dir_d;
         activePeriod_q <= activePeriod_d;
         activeMode_q   <= activeMode_d;
         periodStart_q  <= boundary;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      assign wrStrobe[i] = bus.duty_wr && (bus.duty_ch == CHW'(i));

      pwm_chan #(.WIDTH(WIDTH)) u_chan (
         .clk      (clk),
         .rst      (rst),
         .en_i     (bus.en),
         .cnt_i    (cnt_q),
         .period_i (activePeriod_d),
         .mode_i   (activeMode_d),
         .load_i   (load),
         .wr_i     (wrStrobe[i]),
         .wr_val_i (bus.duty_val),
         .pwm_o    (pwmOut[i])
      );
   end

   assign bus.pwm_out      = pwmOut;
   assign bus.period_start = periodStart_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: a phase-based period model predicts every output cycle,
// and an independent monitor compares the DUT pins one cycle after each stimulus.
module tb_pwm_multi;

   localparam int W   = 10;
   localparam int NCH = 3;
   localparam int CHW = 2;

   typedef struct packed {
      logic [NCH-1:0] pwm;
      logic           ps;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   pwm_multi_if #(.WIDTH(W), .NCH(NCH)) bus ();

   pwm_multi #(.WIDTH(W), .NCH(NCH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   exp_t expQ[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   cycleNo    = 0;

   logic curRst, curEn, curMode;
   int   curPeriod;

   // Reference state: position within the current period rather than a counter value.
   int mShadow[NCH];
   int mDuty[NCH];
   int mP, mMode, mK;

   function automatic int clampP(input int p);
      return (p < 2) ? 2 : p;
   endfunction

   // Edge: high for the first D cycles. Center: 2D cycles around the turnaround at phase P.
   function automatic logic expectHigh(input int k, input int d, input int p, input int m);
      if (m == 0) return (k < d);
      return (k >= p - d) && (k < p + d);
   endfunction

   task automatic modelStep(input logic wr, input int ch, input int val);
      exp_t e;
      logic bnd;
      e = '0;
      if (curRst) begin
         for (int i = 0; i < NCH; i++) begin
            mShadow[i] = 0;
            mDuty[i]   = 0;
         end
         mP    = 2;
         mMode = 0;
         mK    = 0;
      end else begin
         bnd = curEn && (mK == 0);
         if (bnd || !curEn) begin
            mP    = clampP(curPeriod);
            mMode = int'(curMode);
            for (int i = 0; i < NCH; i++) mDuty[i] = mShadow[i];
         end
         e.ps = bnd;
         for (int i = 0; i < NCH; i++)
            e.pwm[i] = curEn && expectHigh(mK, mDuty[i], mP, mMode);
         if (wr && ch < NCH) mShadow[ch] = val;
         mK = curEn ? (mK + 1) % ((mMode != 0) ? 2 * mP : mP) : 0;
      end
      expQ.push_back(e);
   endtask

   task automatic applyStimulus(input logic wr, input int ch, input int val);
      @(negedge clk);
      rst          = curRst;
      bus.en       = curEn;
      bus.mode     = curMode;
      bus.period   = W'(curPeriod);
      bus.duty_wr  = wr;
      bus.duty_ch  = CHW'(ch);
      bus.duty_val = W'(val);
      modelStep(wr, ch, val);
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 0, 0);
   endtask

   task automatic waitPhase(input int target, input int limit);
      int n;
      n = 0;
      while (mK != target && n < limit) begin
         applyStimulus(1'b0, 0, 0);
         n++;
      end
      if (mK != target) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL waitPhase: phase %0d, required %0d within %0d cycles", mK, target, limit);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      compared++;
      if (bus.pwm_out !== e.pwm) begin
         mismatched++;
         $display("[TB] FAIL pwm_out cycle %0d: got %b, expected %b", cycleNo, bus.pwm_out, e.pwm);
      end
      compared++;
      if (bus.period_start !== e.ps) begin
         mismatched++;
         $display("[TB] FAIL period_start cycle %0d: got %b, expected %b", cycleNo, bus.period_start, e.ps);
      end
   endtask

   // Monitor: one scoreboard entry per clock, compared shortly after the edge.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cycleNo++;
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin : driver
      rst          = 1'b1;
      bus.en       = 1'b0;
      bus.mode     = 1'b0;
      bus.period   = '0;
      bus.duty_wr  = 1'b0;
      bus.duty_ch  = '0;
      bus.duty_val = '0;
      curRst = 1'b1; curEn = 1'b0; curMode = 1'b0; curPeriod = 10;

      $display("[TB] reset");
      idle(3);
      curRst = 1'b0;

      $display("[TB] edge mode, period 10, ch0 duty 3");
      applyStimulus(1'b1, 0, 3);
      curEn = 1'b1;
      idle(35);

      $display("[TB] duty 0 and duty above period");
      applyStimulus(1'b1, 1, 0);
      applyStimulus(1'b1, 2, 12);
      idle(30);

      $display("[TB] center mode, period 8, duty 3");
      curMode = 1'b1; curPeriod = 8;
      applyStimulus(1'b1, 0, 3);
      idle(40);

      $display("[TB] write mid-period and on boundary");
      curMode = 1'b0; curPeriod = 10;
      waitPhase(0, 40);
      waitPhase(4, 40);
      applyStimulus(1'b1, 0, 5);
      waitPhase(0, 40);
      applyStimulus(1'b1, 0, 7);
      idle(25);

      $display("[TB] invalid channel and clamped periods");
      applyStimulus(1'b1, 1, 1);
      applyStimulus(1'b1, 3, 9);
      curPeriod = 0;
      idle(12);
      curPeriod = 1;
      idle(12);
      curMode = 1'b1;
      idle(12);

      $display("[TB] reset mid-pulse");
      curMode = 1'b0; curPeriod = 10;
      waitPhase(0, 40);
      waitPhase(2, 40);
      curRst = 1'b1;
      idle(1);
      curRst = 1'b0;
      idle(25);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 700; n++) begin
         curRst = ($urandom_range(0, 199) == 0);
         curEn  = ($urandom_range(0, 19) != 0);
         if ($urandom_range(0, 29) == 0) begin
            curMode   = 1'($urandom_range(0, 1));
            curPeriod = int'($urandom_range(0, 20));
         end
         applyStimulus(($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 24)));
      end
      curRst = 1'b0;
      idle(2);

      repeat (3) @(posedge clk);
      #2;
      compared++;
      if (expQ.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", expQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Parametrised multi-channel PWM generator: the next generation of the team's single-channel 10-bit PWM. One shared period counter drives NCH independent compare channels. Each channel has a double-buffered duty register, updated only at period boundaries. Edge-aligned and center-aligned modes are both supported. The block sits between the register/command interface and the motor/LED drive pins.

## Interface
Parameters:
- WIDTH, 10, bit width of the period, duty and counter values
- NCH, 4, number of PWM channels (≥1)

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable
- mode  in  1  0 = edge-aligned, 1 = center-aligned
- period  in  WIDTH  counter modulus; values below 2 are clamped to 2
- duty_wr  in  1  one-cycle shadow-duty write strobe
- duty_ch  in  max(1,$clog2(NCH))  channel selected by duty_wr
- duty_val  in  WIDTH  duty value to write
- pwm_out  out  NCH  PWM outputs, registered
- period_start  out  1  one-cycle pulse marking the first output cycle of each period

## Operation
- Reset values: cnt=0, dir=up, every shadow and active duty = 0, active period=2, active mode=0, pwm_out=0, period_start=0.
- Boundary cycle:
  - en=1 and the counter is at the start of a period (cnt=0, dir=up).
  - At boundary: active_period←clamp(period), active_mode←mode, active_duty[i]←shadow[i] for all i.
- While en=0: the counter is held at cnt=0/dir=up and pwm_out is driven to 0. Active registers reload from inputs and shadows every cycle, so the first period after en rises uses current values.
- Shadow write: when duty_wr=1 and duty_ch<NCH, shadow[duty_ch]←duty_val. Writes with duty_ch≥NCH are ignored.
- Write on a boundary cycle: the load uses the old shadow value. The new value takes effect at the next boundary.
- Edge mode:
  - cnt runs 0,1,…,P−1 and wraps to 0. Period length is P cycles.
  - Output high when cnt < D.
- Center mode:
  - Up phase counts 0…P−1; the down phase then counts P−1…0 (each value appears twice). Period length is 2P cycles.
  - Output high when cnt ≥ P−D. The high pulse is contiguous, 2D cycles long, and centered on the up/down turnaround.
- Duty limits (both modes): D=0 gives constant low. D≥P gives constant high, including across the wrap (no glitch).
- A mode change takes effect only at a boundary. The counter restarts at 0/up from the boundary.
- Counter arithmetic is WIDTH bits unsigned and never overflows, because cnt ≤ P−1 ≤ 2^WIDTH−2.

## Timing
- pwm_out[i] in cycle t+1 is the compare result of cnt(t) against active_duty[i]. Latency is 1 cycle.
- period_start in cycle t+1 = 1 iff cycle t was a boundary cycle. It coincides with the first output cycle of the new period.
- Duty write to output effect: at the first boundary strictly after the write cycle, plus 1 cycle.
- en falling: pwm_out=0 from the next cycle. en rising in cycle t: cycle t is a boundary, and the first period output appears at t+1.
- rst has priority over en and duty_wr. Reset mid-period gives all reset values on the next cycle, with no partial pulse.

## Structure
- Package pwm_pkg holds:
  - the default WIDTH and NCH
  - the mode encoding constants MODE_EDGE=0 and MODE_CENTER=1
  - the minimum-period constant PERIOD_MIN=2
- Sub-module pwm_chan, instantiated NCH times. Each instance holds one shadow register, one active register, the compare logic and the output flop. Its inputs are cnt, active_period, active_mode, the load strobe and the write strobe.
- The top level holds the counter, direction flag, active period/mode, boundary detect, period_start and the write decode.

## Test plan
- Reset, then en=1, mode=0, period=10, ch0 duty=3 → ch0 is 3 cycles high and 7 low, repeating. period_start pulses every 10 cycles, aligned with the first high cycle.
- Edge mode, period=10, ch1 duty=0 and ch2 duty=12 → ch1 stays 0 and ch2 stays 1 continuously, with no wrap glitch.
- mode=1, period=8, duty=3 → 16-cycle period. Output is high for 6 contiguous cycles at cnt 5,6,7,7,6,5.
- Write duty 5 to ch0 mid-period and write 7 on the boundary cycle → 5 appears at the next boundary and 7 at the boundary after that. The old duty holds until then.
- duty_wr with duty_ch=NCH → no shadow changes. period=0 or 1 → behaves as period=2.
- Assert rst mid-pulse with en=1 → next cycle pwm_out=0, period_start=0, shadows=0. After release, outputs stay low until new duties are written.
